// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multicycle datapath.
// Holds the sequencer state encoding, the ALU operation codes, and the
// opcode/funct field values recognised by the decoder. Imported by the ALU,
// the control sequencer and its funct decoder so that every producer and
// consumer of an ALU operation code agrees on the encoding.
package ctrl_pkg;

    // Sequencer state encoding
    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_EXEC_R   = 4'd3;
    localparam state_t S_EXEC_I   = 4'd4;
    localparam state_t S_MEM_ADDR = 4'd5;
    localparam state_t S_MEM_RD   = 4'd6;
    localparam state_t S_MEM_WR   = 4'd7;
    localparam state_t S_WB_R     = 4'd8;
    localparam state_t S_WB_MEM   = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_ILLEGAL  = 4'd11;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Funct field values (IR[5:0]) for R-type instructions
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct decoder.
// Maps the funct field onto an ALU operation code and flags whether the
// funct is one the datapath supports. Purely combinational; used both to
// drive the ALU in EXEC_R and to judge R-type legality in DECODE.
//
// Ports:
//   funct   in   OPW     IR[5:0]
//   alu_op  out  ALUOPW  ALU operation for this funct (ADD when unsupported)
//   valid   out  1       funct is supported
module alu_op_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW    = 6,
    parameter int unsigned ALUOPW = 4
) (
    input  logic [OPW-1:0]    funct,
    output logic [ALUOPW-1:0] alu_op,
    output logic              valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, producing the ALU operation code, the ALU operand select and
// every datapath write enable. Branches are resolved from the ALU zero flag
// in the BRANCH state.
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   opcode      in   OPW     IR[31:26], valid from DECODE onward
//   funct       in   OPW     IR[5:0]
//   zero        in   1       ALU zero flag, sampled in BRANCH
//   mem_ready   in   1       memory completion for the current request
//   aluOp       out  ALUOPW  ALU operation code
//   alu_src     out  1       0 = register operand, 1 = sign-extended immediate
//   mem_req     out  1       memory request
//   mem_we      out  1       memory write qualifier
//   ir_write    out  1       instruction register load
//   pc_write    out  1       program counter load
//   reg_write   out  1       register file write
//   reg_dst     out  1       1 = rd, 0 = rt as destination
//   mem_to_reg  out  1       write-back from memory data
//   instr_done  out  1       one-cycle pulse on retirement
//   illegal     out  1       one-cycle pulse on an unsupported instruction
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW    = 6,
    parameter int unsigned ALUOPW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic [ALUOPW-1:0] aluOp,
    output logic              alu_src,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              instr_done,
    output logic              illegal
);

    state_t state_q;
    state_t state_d;

    // Remembers whether the instruction in flight is R-type so WB_R can pick
    // rd versus rt without re-decoding.
    logic rtype_q;
    logic rtype_d;

    logic [ALUOPW-1:0] funct_alu_op;
    logic              funct_valid;

    alu_op_decode #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW)
    ) u_alu_op_decode (
        .funct  (funct),
        .alu_op (funct_alu_op),
        .valid  (funct_valid)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rtype_d = rtype_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                rtype_d = (opcode == OP_RTYPE);
                case (opcode)
                    OP_RTYPE:     state_d = funct_valid ? S_EXEC_R : S_ILLEGAL;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_ILLEGAL;
                endcase
            end

            S_EXEC_R, S_EXEC_I: state_d = S_WB_R;

            // IR still holds the instruction, so the opcode picks load or store.
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;

            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end

            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_WB_R, S_WB_MEM, S_BRANCH, S_ILLEGAL: state_d = S_FETCH;

            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: Moore outputs from the state register, plus the few
    // that must react to mem_ready or zero within the same cycle.
    always_comb begin
        aluOp      = ALU_ADD;
        alu_src    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // ALU computes PC+4 while the instruction is read
                mem_req  = 1'b1;
                alu_src  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end

            S_DECODE: ;

            S_EXEC_R: begin
                aluOp   = funct_alu_op;
                alu_src = 1'b0;
            end

            S_EXEC_I, S_MEM_ADDR: begin
                alu_src = 1'b1;
            end

            S_MEM_RD: begin
                mem_req = 1'b1;
            end

            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                instr_done = mem_ready;
            end

            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = rtype_q;
                instr_done = 1'b1;
            end

            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end

            S_BRANCH: begin
                aluOp      = ALU_SUB;
                alu_src    = 1'b0;
                pc_write   = zero;
                instr_done = 1'b1;
            end

            S_ILLEGAL: begin
                illegal = 1'b1;
            end

            // IDLE and unknown encodings drive every output low
            default: begin
                aluOp = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rtype_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rtype_q <= rtype_d;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm. Each instruction is expanded into a per-cycle
// list of {inputs to drive, outputs required} from the instruction-level
// rules; the list is then played into the DUT and compared cycle by cycle.
module tb_mc_control_fsm;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        logic       rst_n;
        logic       mem_ready;
        logic       zero;
        logic [5:0] opcode;
        logic [5:0] funct;
        outs_t      exp;
    } rec_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] aluOp;
    logic       alu_src;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_illegal = 0;
    int n_done    = 0;
    int n_mem_we  = 0;
    int n_pc_wr   = 0;

    rec_t trace[$];

    mc_control_fsm #(
        .OPW    (6),
        .ALUOPW (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .aluOp      (aluOp),
        .alu_src    (alu_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom_range(63));
    endfunction

    function automatic outs_t base_add();
        outs_t o;
        o = '0;
        o.alu_op = 4'b0010;
        return o;
    endfunction

    // Supported R-type functs and their ALU codes
    task automatic fn_decode(input logic [5:0] fn, output logic [3:0] aop, output logic ok);
        ok  = 1'b1;
        aop = 4'b0010;
        case (fn)
            6'b100000: aop = 4'b0010;
            6'b100010: aop = 4'b0110;
            6'b100100: aop = 4'b0000;
            6'b100101: aop = 4'b0001;
            default:   ok  = 1'b0;
        endcase
    endtask

    task automatic push(input logic r, input logic rdy, input logic z,
                        input logic [5:0] op, input logic [5:0] fn, input outs_t e);
        rec_t t;
        t.rst_n     = r;
        t.mem_ready = rdy;
        t.zero      = z;
        t.opcode    = op;
        t.funct     = fn;
        t.exp       = e;
        trace.push_back(t);
    endtask

    task automatic push_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), r6(), r6(), '0);
        // one idle cycle after release, everything low
        push(1'b1, rb(), rb(), r6(), r6(), '0);
    endtask

    // Fetch with fw wait cycles, then the decode cycle
    task automatic push_fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int fw);
        outs_t e;
        for (int i = 0; i < fw; i++) begin
            e = base_add(); e.mem_req = 1'b1; e.alu_src = 1'b1;
            push(1'b1, 1'b0, rb(), r6(), r6(), e);
        end
        e = base_add(); e.mem_req = 1'b1; e.alu_src = 1'b1;
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b1, 1'b1, rb(), r6(), r6(), e);
        push(1'b1, rb(), rb(), op, fn, base_add());
    endtask

    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        outs_t e;
        logic [3:0] aop;
        logic fv;
        logic is_sw;
        push_fetch_decode(op, fn, fw);
        fn_decode(fn, aop, fv);
        is_sw = (op == 6'b101011);
        if (op == 6'b000000 && fv) begin
            e = base_add(); e.alu_op = aop;
            push(1'b1, rb(), rb(), op, fn, e);
            e = base_add(); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
            push(1'b1, rb(), rb(), op, fn, e);
        end else if (op == 6'b001000) begin
            e = base_add(); e.alu_src = 1'b1;
            push(1'b1, rb(), rb(), op, fn, e);
            e = base_add(); e.reg_write = 1'b1; e.instr_done = 1'b1;
            push(1'b1, rb(), rb(), op, fn, e);
        end else if (op == 6'b100011 || is_sw) begin
            e = base_add(); e.alu_src = 1'b1;
            push(1'b1, rb(), rb(), op, fn, e);
            for (int i = 0; i < mw; i++) begin
                e = base_add(); e.mem_req = 1'b1; e.mem_we = is_sw;
                push(1'b1, 1'b0, rb(), op, fn, e);
            end
            e = base_add(); e.mem_req = 1'b1; e.mem_we = is_sw; e.instr_done = is_sw;
            push(1'b1, 1'b1, rb(), op, fn, e);
            if (!is_sw) begin
                e = base_add(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
                push(1'b1, rb(), rb(), op, fn, e);
            end
        end else if (op == 6'b000100) begin
            e = base_add(); e.alu_op = 4'b0110; e.pc_write = z; e.instr_done = 1'b1;
            push(1'b1, rb(), z, op, fn, e);
        end else begin
            e = base_add(); e.illegal = 1'b1;
            push(1'b1, rb(), rb(), op, fn, e);
        end
    endtask

    // sw whose store is still waiting when reset hits; no write may complete
    task automatic add_sw_abort(input int k);
        outs_t e;
        push_fetch_decode(6'b101011, r6(), 0);
        e = base_add(); e.alu_src = 1'b1;
        push(1'b1, rb(), rb(), 6'b101011, 6'd0, e);
        for (int i = 0; i < k; i++) begin
            e = base_add(); e.mem_req = 1'b1; e.mem_we = 1'b1;
            push(1'b1, 1'b0, rb(), 6'b101011, 6'd0, e);
        end
        push_reset(2);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic run_trace();
        rec_t t;
        outs_t got;
        while (trace.size() > 0) begin
            t = trace.pop_front();
            @(negedge clk);
            rst_n     = t.rst_n;
            mem_ready = t.mem_ready;
            zero      = t.zero;
            opcode    = t.opcode;
            funct     = t.funct;
            #3;
            got = {aluOp, alu_src, mem_req, mem_we, ir_write, pc_write, reg_write,
                   reg_dst, mem_to_reg, instr_done, illegal};
            checks++;
            if (got !== t.exp) begin
                errors++;
                $display("FAIL outputs cycle %0d: got aluOp/src/req/we/irw/pcw/rw/dst/m2r/done/ill=%b required %b",
                         cyc, got, t.exp);
            end
            n_illegal += int'(illegal === 1'b1);
            n_done    += int'(instr_done === 1'b1);
            n_mem_we  += int'(mem_we === 1'b1);
            n_pc_wr   += int'(pc_write === 1'b1);
            cyc++;
        end
    endtask

    initial begin
        int n0;
        logic [5:0] op;
        logic [5:0] fn;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;

        // Directed sequence, with model lengths pinned to hand-counted cycles
        push_reset(2);
        n0 = trace.size();
        add_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
        check_int("add length", trace.size() - n0, 4);
        check_int("add exec aluOp", int'(trace[n0 + 2].exp.alu_op), 2);
        check_int("add exec alu_src", int'(trace[n0 + 2].exp.alu_src), 0);
        n0 = trace.size();
        add_instr(6'b100011, 6'd0, 0, 3, 1'b0);
        check_int("lw wait3 length", trace.size() - n0, 8);
        n0 = trace.size();
        add_instr(6'b000100, 6'd0, 0, 0, 1'b1);
        check_int("beq taken length", trace.size() - n0, 3);
        add_instr(6'b000100, 6'd0, 0, 0, 1'b0);
        n0 = trace.size();
        add_instr(6'b111111, r6(), 0, 0, 1'b0);
        check_int("illegal op length", trace.size() - n0, 3);
        add_instr(6'b000000, 6'b101010, 0, 0, 1'b0);
        n0 = trace.size();
        add_instr(6'b101011, 6'd0, 0, 0, 1'b0);
        check_int("sw length", trace.size() - n0, 4);
        add_instr(6'b001000, r6(), 0, 0, 1'b0);
        add_sw_abort(2);
        run_trace();

        check_int("directed illegal pulses", n_illegal, 2);
        check_int("directed instr_done pulses", n_done, 6);
        check_int("directed mem_we cycles", n_mem_we, 3);
        check_int("directed pc_write cycles", n_pc_wr, 10);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            fn = r6();
            case ($urandom_range(7))
                0: begin
                    op = 6'b000000;
                    if ($urandom_range(3) != 0) begin
                        case ($urandom_range(3))
                            0: fn = 6'b100000;
                            1: fn = 6'b100010;
                            2: fn = 6'b100100;
                            default: fn = 6'b100101;
                        endcase
                    end
                end
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b001000;
                4: op = 6'b000100;
                5: op = 6'b000000;
                default: op = r6();
            endcase
            add_instr(op, fn, $urandom_range(2), $urandom_range(3), rb());
            if (i == 120) add_sw_abort(1);
        end
        run_trace();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
